alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 157 +++++++++++++++
 tb/tb_alu_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle 16-bit ALU with iterative shift-add multiplier.
// Single-cycle ops take EXEC, MUL takes 16 cycles; result/flags written on DONE.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] src,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int W = WIDTH;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [3:0]     cnt;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     shl_x;
  logic [W:0]     shr_x;
  logic [W-1:0]   res_c;
  logic           c_c;
  logic           v_c;
  logic [2*W-1:0] acc_nxt;

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign diff  = {1'b0, a_q} - {1'b0, b_q};
  // Extra bit catches the last bit shifted out; amount 0 leaves it 0.
  assign shl_x = {1'b0, a_q} << b_q[3:0];
  assign shr_x = {a_q, 1'b0} >> b_q[3:0];

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_c = sum[W-1:0];
        c_c   = sum[W];
        v_c   = ~(a_q[W-1] ^ b_q[W-1])
              & (a_q[W-1] ^ sum[W-1]);
      end
      OP_SUB: begin
        res_c = diff[W-1:0];
        c_c   = diff[W];
        v_c   = (a_q[W-1] ^ b_q[W-1])
              & (a_q[W-1] ^ diff[W-1]);
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_SHL: begin
        res_c = shl_x[W-1:0];
        c_c   = shl_x[W];
      end
      OP_SHR: begin
        res_c = shr_x[W:1];
        c_c   = shr_x[0];
      end
      default: res_c = '0;
    endcase
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;
  assign wr_en   = done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            a_q    <= dst;
            b_q    <= src;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, dst};
            mplier <= src;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= (op == OP_MUL) ? S_MUL
                                     : S_EXEC;
          end
        end
        S_EXEC: begin
          result <= res_c;
          flags  <= {res_c == '0, res_c[W-1],
                     c_c, v_c};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            result <= acc_nxt[W-1:0];
            flags  <= {acc_nxt[W-1:0] == '0,
                       acc_nxt[W-1],
                       |acc_nxt[2*W-1:W],
                       1'b0};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq.
// Checks timing of busy/done, result, flags, start-ignore and async reset.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] dst;
  logic [15:0] src;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [15:0] result;
  logic [3:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .dst    (dst),
    .src    (src),
    .busy   (busy),
    .done   (done),
    .wr_en  (wr_en),
    .result (result),
    .flags  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge one cycle after DONE.
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] er,
                        input logic [3:0] ef,
                        input int lat,
                        input int poke);
    op = o; dst = a; src = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = ~o; dst = ~a; src = ~b;
    for (int i = 0; i < lat; i++) begin
      chk({tag, " busy"}, busy, 1'b1);
      chk({tag, " nodone"}, done, 1'b0);
      start = (i == poke);
      if (i == poke) op = 3'd0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " wr_en"}, wr_en, 1'b1);
    chk({tag, " idle"}, busy, 1'b0);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, flags, ef);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " pulse"}, done, 1'b0);
    chk({tag, " ignore"}, busy, 1'b0);
    chk({tag, " hold r"}, result, er);
    chk({tag, " hold f"}, flags, ef);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    op = 3'd0; dst = 16'h0; src = 16'h0;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst wr_en", wr_en, 1'b0);
    chk("rst result", result, 16'h0);
    chk("rst flags", flags, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op("add ovf", 3'd0, 16'h7FFF, 16'h0001,
           16'h8000, 4'b0101, 1, -1);
    run_op("add cy", 3'd0, 16'hFFFF, 16'h0001,
           16'h0000, 4'b1010, 1, -1);
    run_op("sub brw", 3'd1, 16'h0003, 16'h0005,
           16'hFFFE, 4'b0110, 1, -1);
    run_op("sub eq", 3'd1, 16'h1234, 16'h1234,
           16'h0000, 4'b1000, 1, -1);
    run_op("sub v", 3'd1, 16'h8000, 16'h0001,
           16'h7FFF, 4'b0001, 1, -1);
    run_op("and", 3'd2, 16'hF0F0, 16'h0FF0,
           16'h00F0, 4'b0000, 1, -1);
    run_op("or", 3'd3, 16'h0000, 16'h0000,
           16'h0000, 4'b1000, 1, -1);
    run_op("shl", 3'd5, 16'h8001, 16'h0001,
           16'h0002, 4'b0010, 1, -1);
    run_op("shr 0", 3'd6, 16'h0001, 16'h0010,
           16'h0001, 4'b0000, 1, -1);
    run_op("shr 1", 3'd6, 16'h0003, 16'h0001,
           16'h0001, 4'b0010, 1, -1);
    run_op("shr 15", 3'd6, 16'h8000, 16'h000F,
           16'h0001, 4'b0000, 1, -1);
    run_op("mul", 3'd7, 16'h0100, 16'h0101,
           16'h0100, 4'b0010, 16, 4);
    run_op("mul max", 3'd7, 16'hFFFF, 16'hFFFF,
           16'h0001, 4'b0010, 16, -1);
    run_op("mul small", 3'd7, 16'h0007, 16'h0009,
           16'h003F, 4'b0000, 16, -1);

    op = 3'd7; dst = 16'h0100; src = 16'h0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mrst busy pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("mrst busy", busy, 1'b0);
    chk("mrst done", done, 1'b0);
    chk("mrst wr_en", wr_en, 1'b0);
    chk("mrst result", result, 16'h0);
    chk("mrst flags", flags, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("mrst nodone", done, 1'b0);
    end
    rst = 1'b1;
    run_op("xor post", 3'd4, 16'hFFFF, 16'h00FF,
           16'hFF00, 4'b0100, 1, -1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
